// File: rtl/l1mtx_output_arb.sv
// Per-output-port arbiter for the L1 AHB bus matrix: address-phase grant, data-phase owner tracking,
// burst/lock hold. Define L1MTX_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module l1mtx_output_arb #(
  parameter int NUM_IN = 3,
  parameter int IDW    = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NUM_IN-1:0] req_in,
  input  logic [1:0]        HTRANSM,
  input  logic [2:0]        HBURSTM,
  input  logic              HMASTLOCKM,
  input  logic              HREADYM,
  output logic [IDW-1:0]    addr_in_port,
  output logic              no_port,
  output logic [IDW-1:0]    data_in_port,
  output logic              data_valid
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  logic [IDW-1:0] addr_q, addr_d;
  logic           nop_q, nop_d;
  logic [IDW-1:0] data_q, data_d;
  logic           dv_q, dv_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     cnt_next;
  logic           owner_req;
  logic           hold;
  logic           any_req;
  logic [IDW-1:0] winner;
`ifndef L1MTX_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] last_q, last_d;
`endif

  // Remaining beats of a defined-length burst after the current address phase.
  always_comb begin
    cnt_next = cnt_q;
    case (HTRANSM)
      HT_NONSEQ: begin
        case (HBURSTM)
          3'd2, 3'd3: cnt_next = 4'd3;
          3'd4, 3'd5: cnt_next = 4'd7;
          3'd6, 3'd7: cnt_next = 4'd15;
          default:    cnt_next = 4'd0;
        endcase
      end
      HT_SEQ:  cnt_next = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      HT_BUSY: cnt_next = cnt_q;
      HT_IDLE: cnt_next = 4'd0;
      default: cnt_next = 4'd0;
    endcase
    if (nop_q) cnt_next = 4'd0;
  end

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (addr_q == IDW'(i)) owner_req = req_in[i];
    end
    hold = ~nop_q & owner_req & (HMASTLOCKM | (cnt_next != 4'd0));
  end

  always_comb begin
    any_req = |req_in;
    winner  = '0;
`ifdef L1MTX_ARB_FIXED_PRIO_EN
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (req_in[i]) winner = IDW'(i);
    end
`else
    // Scan downwards so the last assignment is the nearest requester after last_q.
    for (int k = NUM_IN; k >= 1; k--) begin
      int idx;
      idx = int'(last_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (req_in[idx]) winner = IDW'(idx);
    end
`endif
  end

  always_comb begin
    addr_d = addr_q;
    nop_d  = nop_q;
    data_d = data_q;
    dv_d   = dv_q;
    cnt_d  = cnt_q;
`ifndef L1MTX_ARB_FIXED_PRIO_EN
    last_d = last_q;
`endif
    if (HREADYM) begin
      cnt_d  = cnt_next;
      data_d = addr_q;
      dv_d   = ~nop_q & HTRANSM[1];
      if (!hold) begin
        if (any_req) begin
          addr_d = winner;
          nop_d  = 1'b0;
`ifndef L1MTX_ARB_FIXED_PRIO_EN
          last_d = winner;
`endif
        end else begin
          nop_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      nop_q  <= 1'b1;
      data_q <= '0;
      dv_q   <= 1'b0;
      cnt_q  <= 4'd0;
`ifndef L1MTX_ARB_FIXED_PRIO_EN
      last_q <= IDW'(NUM_IN - 1);
`endif
    end else begin
      addr_q <= addr_d;
      nop_q  <= nop_d;
      data_q <= data_d;
      dv_q   <= dv_d;
      cnt_q  <= cnt_d;
`ifndef L1MTX_ARB_FIXED_PRIO_EN
      last_q <= last_d;
`endif
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = nop_q;
  assign data_in_port = data_q;
  assign data_valid   = dv_q;

endmodule

// File: tb/tb_l1mtx_output_arb.sv
// Bench for l1mtx_output_arb: vector table of per-beat inputs and expected outputs,
// plus hand-written async-reset and park sequences, checked through an expected queue.
module tb_l1mtx_output_arb;

  localparam int NUM_IN = 3;
  localparam int IDW    = 2;
  localparam int OW     = 2 * IDW + 2;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SNGL = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5;

  logic              HCLK;
  logic              HRESETn;
  logic [NUM_IN-1:0] req_in;
  logic [1:0]        HTRANSM;
  logic [2:0]        HBURSTM;
  logic              HMASTLOCKM;
  logic              HREADYM;
  logic [IDW-1:0]    addr_in_port;
  logic              no_port;
  logic [IDW-1:0]    data_in_port;
  logic              data_valid;

  typedef struct {
    logic [2:0] req;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       lk;
    logic       rdy;
    logic [1:0] ea;
    logic       en;
    logic [1:0] ed;
    logic       ev;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] exp_q[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  l1mtx_output_arb #(.NUM_IN(NUM_IN), .IDW(IDW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_in(req_in), .HTRANSM(HTRANSM),
    .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .HREADYM(HREADYM),
    .addr_in_port(addr_in_port), .no_port(no_port),
    .data_in_port(data_in_port), .data_valid(data_valid)
  );

  // Clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic add(input logic [2:0] req, input logic [1:0] tr, input logic [2:0] bu,
                     input logic lk, input logic rdy, input logic [1:0] ea, input logic en,
                     input logic [1:0] ed, input logic ev);
    vec_t v;
    v.req = req; v.tr = tr; v.bu = bu; v.lk = lk; v.rdy = rdy;
    v.ea = ea; v.en = en; v.ed = ed; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic expect_out(input logic [1:0] ea, input logic en, input logic [1:0] ed, input logic ev);
    exp_q.push_back({ea, en, ed, ev});
  endtask

  // Scoreboard: pop one expectation and compare against the live outputs.
  task automatic check(input string name);
    logic [OW-1:0] exp_v, act_v;
    act_v = {addr_in_port, no_port, data_in_port, data_valid};
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: expected queue empty, got addr/nop/data/dv=%b", name, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v === exp_v) pass_cnt++;
      else $display("FAIL %s: addr/nop/data/dv got %b expected %b", name, act_v, exp_v);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    req_in = v.req; HTRANSM = v.tr; HBURSTM = v.bu; HMASTLOCKM = v.lk; HREADYM = v.rdy;
    expect_out(v.ea, v.en, v.ed, v.ev);
    @(posedge HCLK);
    #1;
    check(name);
  endtask

  initial begin
    int n_idle;
    HRESETn = 1'b0; req_in = '0; HTRANSM = IDLE; HBURSTM = SNGL; HMASTLOCKM = 1'b0; HREADYM = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    expect_out(2'd0, 1'b1, 2'd0, 1'b0);
    check("reset_state");
    HRESETn = 1'b1;

    // Idle with no requests: parked for a random number of beats.
    n_idle = $urandom_range(2, 5);
    for (int i = 0; i < n_idle; i++) add(3'b000, IDLE, SNGL, 0, 1, 0, 1, 0, 0);

`ifdef L1MTX_ARB_FIXED_PRIO_EN
    add(3'b110, IDLE, SNGL, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(3'b110, NSEQ, SNGL, 0, 1, 1, 0, 1, 1);
    add(3'b111, NSEQ, SNGL, 0, 1, 0, 0, 1, 1);
    add(3'b101, NSEQ, SNGL, 0, 1, 0, 0, 0, 1);
    add(3'b100, NSEQ, SNGL, 0, 1, 2, 0, 0, 1);
`else
    // Round-robin with SINGLE transfers: 0,1,2,0,1
    add(3'b111, IDLE, SNGL, 0, 1, 0, 0, 0, 0);
    add(3'b111, NSEQ, SNGL, 0, 1, 1, 0, 0, 1);
    add(3'b111, NSEQ, SNGL, 0, 1, 2, 0, 1, 1);
    add(3'b111, NSEQ, SNGL, 0, 1, 0, 0, 2, 1);
    add(3'b111, NSEQ, SNGL, 0, 1, 1, 0, 0, 1);
    // Port 1 INCR4 with a BUSY inserted
    add(3'b111, NSEQ, INCR4, 0, 1, 1, 0, 1, 1);
    add(3'b111, SEQ,  INCR4, 0, 1, 1, 0, 1, 1);
    add(3'b111, BUSY, INCR4, 0, 1, 1, 0, 1, 0);
    add(3'b111, SEQ,  INCR4, 0, 1, 1, 0, 1, 1);
    add(3'b111, SEQ,  INCR4, 0, 1, 2, 0, 1, 1);
    // Port 0 locked, with stalls
    add(3'b111, NSEQ, SNGL, 0, 1, 0, 0, 2, 1);
    add(3'b111, NSEQ, SNGL, 1, 1, 0, 0, 0, 1);
    add(3'b111, IDLE, SNGL, 1, 1, 0, 0, 0, 0);
    add(3'b111, NSEQ, SNGL, 1, 0, 0, 0, 0, 0);
    add(3'b111, NSEQ, SNGL, 1, 1, 0, 0, 0, 1);
    add(3'b111, NSEQ, SNGL, 1, 1, 0, 0, 0, 1);
    add(3'b111, NSEQ, SNGL, 1, 1, 0, 0, 0, 1);
    add(3'b111, NSEQ, SNGL, 0, 0, 0, 0, 0, 1);
    add(3'b111, NSEQ, SNGL, 0, 1, 1, 0, 0, 1);
    // Port 2 INCR8 cut short by IDLE
    add(3'b111, NSEQ, SNGL,  0, 1, 2, 0, 1, 1);
    add(3'b111, NSEQ, INCR8, 0, 1, 2, 0, 2, 1);
    add(3'b111, SEQ,  INCR8, 0, 1, 2, 0, 2, 1);
    add(3'b111, IDLE, INCR8, 0, 1, 0, 0, 2, 0);
    // Owner drops its request mid-burst
    add(3'b111, NSEQ, INCR4, 0, 1, 0, 0, 0, 1);
    add(3'b110, SEQ,  INCR4, 0, 1, 1, 0, 0, 1);
    // Park with stable select, then one-cycle grant latency
    add(3'b000, NSEQ, SNGL, 0, 1, 1, 1, 1, 1);
    add(3'b000, IDLE, SNGL, 0, 1, 1, 1, 1, 0);
    add(3'b001, IDLE, SNGL, 0, 1, 0, 0, 1, 0);
    add(3'b100, NSEQ, SNGL, 0, 1, 2, 0, 0, 1);
`endif

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

`ifndef L1MTX_ARB_FIXED_PRIO_EN
    // Async reset in the middle of a burst, then pointer must be back at NUM_IN-1.
    begin
      vec_t v;
      v.req = 3'b111; v.tr = IDLE; v.bu = SNGL; v.lk = 0; v.rdy = 1;
      v.ea = 0; v.en = 0; v.ed = 2; v.ev = 0;
      step(v, "pre_rst_grant0");
      v.tr = NSEQ; v.bu = INCR4; v.ea = 0; v.en = 0; v.ed = 0; v.ev = 1;
      step(v, "pre_rst_incr4");
      #2;
      HRESETn = 1'b0;
      #1;
      expect_out(2'd0, 1'b1, 2'd0, 1'b0);
      check("async_reset_midburst");
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      v.tr = IDLE; v.bu = SNGL; v.ea = 0; v.en = 0; v.ed = 0; v.ev = 0;
      step(v, "post_rst_ptr");
    end
`endif

    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL leftover_expectations: %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
